// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } state_e;

  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_req_ctrl.sv
// Data-memory request sequencer: owns the IDLE/MEM FSM, the registered
// request fields and the upstream stall.
module dmem_req_ctrl
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_i,
  input  logic              is_load_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              dmem_ready_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o
);

  state_e            state_q;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Ready is only meaningful while a request is outstanding.
  assign done_o       = (state_q == MEM) & dmem_ready_i;
  assign stall_o      = (state_q == MEM) & ~dmem_ready_i;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

  // FSM and request registers; fields stay frozen until ready completes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_i) begin
            state_q <= MEM;
            req_q   <= 1'b1;
            we_q    <= ~is_load_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
          end else begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        MEM: begin
          if (dmem_ready_i && issue_i) begin
            state_q <= MEM;
            req_q   <= 1'b1;
            we_q    <= ~is_load_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
          end else if (dmem_ready_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else begin
            state_q <= MEM;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: trap screening, memory access via dmem_req_ctrl and
// the register-file write port.
module mem_wb_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_write_addr,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_alu_overflow,
  input  logic              ex_ovf_trap,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_RegWrite,
  input  logic              ex_MemRead,
  input  logic              ex_MemWrite,
  input  logic              ex_MemtoReg,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              exc_ovf,
  output logic              exc_align
);

  logic mem_op_s, ovf_s, align_s, accept_s, issue_s, done_s, stall_s;
  logic alu_wr_s, ld_wr_s;
  logic [DATA_W-1:0] ld_data_s;

  // Pending load bookkeeping, captured at issue and consumed at completion.
  logic              pend_wr_q;
  logic [REG_AW-1:0] pend_addr_q;
  logic              pend_m2r_q;
  logic [DATA_W-1:0] pend_alu_q;

  // One-entry hold for a non-memory write colliding with a completing load.
  logic              hold_v_q, hold_v_d;
  logic [REG_AW-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              exc_ovf_q, exc_align_q;

  // Overflow outranks alignment, so alignment only fires without an overflow trap.
  assign mem_op_s = ex_MemRead | ex_MemWrite;
  assign ovf_s    = ex_ovf_trap & ex_alu_overflow;
  assign align_s  = mem_op_s & is_misaligned(ex_alu_result) & ~ovf_s;
  assign accept_s = ex_valid & ~stall_s;
  assign issue_s  = accept_s & mem_op_s & ~ovf_s & ~align_s;
  assign alu_wr_s = accept_s & ~mem_op_s & ~ovf_s & ex_RegWrite
                    & (ex_write_addr != ZERO_REG);
  assign ld_wr_s   = done_s & pend_wr_q;
  assign ld_data_s = pend_m2r_q ? dmem_rdata : pend_alu_q;

  dmem_req_ctrl u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_i      (issue_s),
    .is_load_i    (ex_MemRead),
    .addr_i       ({ex_alu_result[DATA_W-1:2], 2'b00}),
    .wdata_i      (ex_store_data),
    .dmem_ready_i (dmem_ready),
    .stall_o      (stall_s),
    .done_o       (done_s),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata)
  );

  // Capture load write-back context when a memory op is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_wr_q   <= 1'b0;
      pend_addr_q <= 5'd0;
      pend_m2r_q  <= 1'b0;
      pend_alu_q  <= 32'h0000_0000;
    end else if (issue_s) begin
      pend_wr_q   <= ex_MemRead & ex_RegWrite & (ex_write_addr != ZERO_REG);
      pend_addr_q <= ex_write_addr;
      pend_m2r_q  <= ex_MemtoReg;
      pend_alu_q  <= ex_alu_result;
    end else begin
      pend_wr_q   <= pend_wr_q;
      pend_addr_q <= pend_addr_q;
      pend_m2r_q  <= pend_m2r_q;
      pend_alu_q  <= pend_alu_q;
    end
  end

  // Write-port arbitration: completing load, then held write, then fresh ALU write.
  always_comb begin
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    hold_v_d    = 1'b0;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    if (ld_wr_s || hold_v_q) begin
      wb_en_d   = 1'b1;
      wb_addr_d = ld_wr_s ? pend_addr_q : hold_addr_q;
      wb_data_d = ld_wr_s ? ld_data_s : hold_data_q;
      if (alu_wr_s) begin
        hold_v_d    = 1'b1;
        hold_addr_d = ex_write_addr;
        hold_data_d = ex_alu_result;
      end else begin
        hold_v_d = 1'b0;
      end
    end else if (alu_wr_s) begin
      wb_en_d   = 1'b1;
      wb_addr_d = ex_write_addr;
      wb_data_d = ex_alu_result;
    end else begin
      wb_en_d = 1'b0;
    end
  end

  // Registered write-port, hold entry and exception pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 32'h0000_0000;
      hold_v_q    <= 1'b0;
      hold_addr_q <= 5'd0;
      hold_data_q <= 32'h0000_0000;
      exc_ovf_q   <= 1'b0;
      exc_align_q <= 1'b0;
    end else begin
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      exc_ovf_q   <= accept_s & ovf_s;
      exc_align_q <= accept_s & align_s;
    end
  end

  assign stall     = stall_s;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign exc_ovf   = exc_ovf_q;
  assign exc_align = exc_align_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scenario bench for mem_wb_stage: expected register writes are queued at
// stimulus time and retired by a write-port monitor.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  ex_write_addr;
  logic [31:0] ex_alu_result;
  logic        ex_alu_overflow, ex_ovf_trap;
  logic [31:0] ex_store_data;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
  logic        stall, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_en, exc_ovf, exc_align;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  typedef struct { logic [4:0] a; logic [31:0] d; } wb_t;
  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_write_addr(ex_write_addr),
    .ex_alu_result(ex_alu_result), .ex_alu_overflow(ex_alu_overflow),
    .ex_ovf_trap(ex_ovf_trap), .ex_store_data(ex_store_data),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .exc_ovf(exc_ovf), .exc_align(exc_align)
  );

  // Write-port monitor: every wb_en must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write", wb_addr, wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (wb_addr !== e.a || wb_data !== e.d) begin
          n_fail++;
          $display("FAIL wb_value: got addr=%0d data=%h, required addr=%0d data=%h",
                   wb_addr, wb_data, e.a, e.d);
        end
      end
    end
  end

  task automatic drive(input logic [4:0] wa, input logic [31:0] res, input logic ovf,
                       input logic trap, input logic [31:0] sd, input logic rw,
                       input logic mr, input logic mw, input logic m2r);
    ex_valid = 1'b1; ex_write_addr = wa; ex_alu_result = res; ex_alu_overflow = ovf;
    ex_ovf_trap = trap; ex_store_data = sd; ex_RegWrite = rw; ex_MemRead = mr;
    ex_MemWrite = mw; ex_MemtoReg = m2r;
  endtask

  task automatic idle_in();
    drive(5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({dmem_req, dmem_we, wb_en, exc_ovf, exc_align, stall} !== 6'b0 ||
        dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || wb_addr !== 5'd0 || wb_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b we=%b wb_en=%b ovf=%b align=%b stall=%b addr=%h wdata=%h wba=%0d wbd=%h, required all 0",
               dmem_req, dmem_we, wb_en, exc_ovf, exc_align, stall, dmem_addr, dmem_wdata, wb_addr, wb_data);
    end
  endtask

  task automatic test_alu();
    @(posedge clk); #1;
    drive(5'd8, 32'h5, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{5'd8, 32'h5});
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b, required 0", stall); end
    @(posedge clk); #1 idle_in();
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0 || wb_en !== 1'b1) begin
      n_fail++; $display("FAIL alu_wb_n1: got wb_en=%b pending=%0d, required wb_en=1 pending=0", wb_en, exp_q.size());
    end
    @(negedge clk);
    n_checks++;
    if (wb_en !== 1'b0) begin n_fail++; $display("FAIL alu_wb_once: got wb_en=%b, required 0", wb_en); end
  endtask

  task automatic test_back_to_back_alu();
    for (int i = 0; i < 6; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = 5'($urandom_range(31, 1));
      d = $urandom;
      @(posedge clk); #1;
      drive(a, d, i[0], 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back('{a, d});
    end
    @(posedge clk); #1 idle_in();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_alu_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_load();
    int stall_cnt = 0;
    @(posedge clk); #1;
    drive(5'd9, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_q.push_back('{5'd9, 32'hDEAD_BEEF});
    @(posedge clk); #1 idle_in();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin
        n_fail++;
        $display("FAIL load_req c%0d: got req=%b we=%b addr=%h, required req=1 we=0 addr=00000100", k, dmem_req, dmem_we, dmem_addr);
      end
      if (k == 3) begin dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF; end
      #1;
      if (stall === 1'b1) stall_cnt++;
    end
    @(posedge clk); #1 dmem_ready = 1'b0; dmem_rdata = 32'h0;
    n_checks++;
    if (stall_cnt != 2) begin n_fail++; $display("FAIL load_stall_cycles: got %0d, required 2", stall_cnt); end
    @(negedge clk); #1;
    n_checks++;
    if (dmem_req !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL load_complete: got req=%b pending=%0d, required req=0 pending=0", dmem_req, exp_q.size());
    end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    drive(5'd5, 32'h104, 1'b0, 1'b0, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1 idle_in();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h104 || dmem_wdata !== 32'h1234) begin
        n_fail++;
        $display("FAIL store_hold c%0d: got req=%b we=%b addr=%h wdata=%h, required 1 1 00000104 00001234", k, dmem_req, dmem_we, dmem_addr, dmem_wdata);
      end
      if (k == 4) dmem_ready = 1'b1;
    end
    @(posedge clk); #1 dmem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b0 || wb_en !== 1'b0) begin
      n_fail++; $display("FAIL store_done: got req=%b wb_en=%b, required 0 0", dmem_req, wb_en);
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_en !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready_ignored: got req=%b stall=%b wb_en=%b, required 0 0 0", dmem_req, stall, wb_en);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_traps();
    logic [2:0] want [3];
    want[0] = 3'b010; want[1] = 3'b100; want[2] = 3'b100;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      if (t == 0) drive(5'd3, 32'h102, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      else if (t == 1) drive(5'd3, 32'h102, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      else drive(5'd4, 32'h8000_0000, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1 idle_in();
      @(negedge clk);
      n_checks++;
      if ({exc_ovf, exc_align, dmem_req} !== want[t]) begin
        n_fail++; $display("FAIL trap%0d_pulse: got ovf/align/req=%b, required %b", t, {exc_ovf, exc_align, dmem_req}, want[t]);
      end
      @(negedge clk);
      n_checks++;
      if ({exc_ovf, exc_align, dmem_req, wb_en} !== 4'b0) begin
        n_fail++; $display("FAIL trap%0d_once: got ovf/align/req/wb=%b, required 0000", t, {exc_ovf, exc_align, dmem_req, wb_en});
      end
    end
  endtask

  task automatic test_zero_reg();
    @(posedge clk); #1;
    drive(5'd0, 32'h7, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 idle_in();
    @(negedge clk);
    n_checks++;
    if (wb_en !== 1'b0) begin n_fail++; $display("FAIL zero_reg: got wb_en=%b, required 0", wb_en); end
  endtask

  task automatic test_back_to_back_mem();
    @(posedge clk); #1;
    drive(5'd10, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_q.push_back('{5'd10, 32'hCAFE_0001});
    @(posedge clk); #1;
    drive(5'd0, 32'h208, 1'b0, 1'b0, 32'hA5A5_0002, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h200) begin
      n_fail++; $display("FAIL b2b_first: got stall=%b we=%b addr=%h, required 1 0 00000200", stall, dmem_we, dmem_addr);
    end
    @(negedge clk);
    dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_0001;
    @(posedge clk); #1 idle_in(); dmem_ready = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h208 || dmem_wdata !== 32'hA5A5_0002) begin
      n_fail++; $display("FAIL b2b_second: got req=%b we=%b addr=%h wdata=%h, required 1 1 00000208 a5a50002", dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ready = 1'b1;
    drive(5'd11, 32'h0000_0042, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{5'd11, 32'h0000_0042});
    @(posedge clk); #1 idle_in(); dmem_ready = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (dmem_req !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got req=%b pending=%0d, required 0 0", dmem_req, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_mem();
    @(posedge clk); #1;
    drive(5'd12, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 idle_in();
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got req=%b, required 1", dmem_req); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, stall, wb_en, exc_ovf, exc_align} !== 6'b0 || dmem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_clear: got req/we/stall/wb/ovf/align=%b addr=%h, required 0", {dmem_req, dmem_we, stall, wb_en, exc_ovf, exc_align}, dmem_addr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive(5'd13, 32'h0000_0099, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('{5'd13, 32'h0000_0099});
    @(posedge clk); #1 idle_in();
    @(negedge clk); #1;
    n_checks++;
    if (wb_en !== 1'b1 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rst_mid_after: got wb_en=%b pending=%0d, required 1 0", wb_en, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_reset();
    test_alu();
    test_back_to_back_alu();
    test_load();
    test_store();
    test_traps();
    test_zero_reg();
    test_back_to_back_mem();
    test_reset_mid_mem();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_drain: got %0d pending, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline stage that consumes the execute stage's results (destination register, ALU result, overflow flag) together with the forwarded store operand and memory/write-back control. It performs the data-memory access over a req/ready handshake, stalling upstream while a request is outstanding. It applies the overflow and alignment trap rules, then drives the register-file write port. It sits between the execute stage and the register file.

## Interface
- No parameters; datapath fixed at 32 bits, register address at 5 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute-stage result valid this cycle
- ex_write_addr  in  5  destination register (already RegDst-selected)
- ex_alu_result  in  32  signed ALU result; also the memory byte address
- ex_alu_overflow  in  1  signed overflow from the ALU
- ex_ovf_trap  in  1  instruction traps on overflow (add/addi/sub)
- ex_store_data  in  32  rt operand for stores
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg  in  1 each  control bits
- stall  out  1  upstream must hold all ex_* stable while high
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  store data
- dmem_ready  in  1  request completes this cycle
- dmem_rdata  in  32  load data, valid when dmem_ready is high
- wb_en  out  1  register-file write enable
- wb_addr  out  5  register-file write address
- wb_data  out  32  register-file write data
- exc_ovf  out  1  one-cycle overflow-trap pulse
- exc_align  out  1  one-cycle misaligned-access pulse

## Operation
- Accept: `ex_valid & ~stall`. Accepted fields latch into the stage register.
- `stall = (state == MEM) & ~dmem_ready`.
- FSM states: IDLE, MEM.
  - IDLE → MEM on accept of an aligned memory op with no trap.
  - MEM → IDLE on `dmem_ready`.
- Memory op: `ex_MemRead | ex_MemWrite`. If both are set, it is treated as a load.
- Alignment: a memory op with `ex_alu_result[1:0] != 0` issues no request. It pulses `exc_align` and writes nothing.
- Overflow trap: `ex_ovf_trap & ex_alu_overflow` pulses `exc_ovf`. There is no write-back and no memory request.
- Trap precedence: overflow over alignment.
- Write data: `MemtoReg ? captured load data : alu_result`.
- Write suppression: `wb_en` is forced to 0 when RegWrite = 0, when `wb_addr == 0`, or after any trap.
- Memory protocol:
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` are registered.
  - They are held constant while `dmem_req & ~dmem_ready`.
  - `dmem_req` deasserts the cycle after `dmem_ready`.
  - `dmem_ready` while `dmem_req = 0` is ignored.
- A new instruction is accepted in the same cycle `dmem_ready` completes the previous one. Back-to-back memory ops then keep `dmem_req` high with updated fields.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `wb_en`, `exc_ovf`, `exc_align` = 0; `dmem_addr`, `dmem_wdata`, `wb_addr`, `wb_data` = 0.
- ALU-only op accepted at cycle N: `wb_en`/`wb_addr`/`wb_data` valid at N+1 for one cycle.
- Memory op accepted at N:
  - `dmem_req` is high from N+1.
  - With `dmem_ready` first high at M ≥ N+1, `stall` is high for cycles N+1..M-1.
  - Load write-back occurs at M+1 using `dmem_rdata` sampled at M.
  - A store produces no write-back.
- Traps: `exc_ovf`/`exc_align` pulse at N+1 for exactly one cycle.
- Reset mid-MEM: the request is dropped immediately, with no write-back and no exception.
- `ex_valid` while stalled is not accepted; the same instruction is accepted once `stall` falls.

## Structure
- Shared package `mips_pkg`: state enum {IDLE, MEM}, `DATA_W = 32`, `REG_AW = 5`, zero-register constant.
- One natural sub-module, `dmem_req_ctrl`: the FSM plus dmem request registers and stall generation. The top level holds the stage register, trap logic and write-back mux.

## Test plan
- ALU op, `ex_alu_result = 0x0000_0005`, `ex_write_addr = 8`, RegWrite = 1, accepted at N → at N+1: `wb_en = 1`, `wb_addr = 8`, `wb_data = 5`. `stall` never asserts.
- Load, `addr = 0x100`, MemtoReg = 1, `dmem_ready` high on the 3rd request cycle with `rdata = 0xDEAD_BEEF` → `stall` is high for 2 cycles, and the following cycle gives `wb_en = 1` with `wb_data = 0xDEAD_BEEF`.
- Store, `addr = 0x104`, `store_data = 0x1234` → `dmem_we = 1`, `dmem_wdata = 0x1234` held until `ready`, and `wb_en` stays 0.
- Load at `addr = 0x102` → no `dmem_req`, `exc_align` pulses once, `wb_en = 0`. Same with `ovf_trap = 1` and `overflow = 1` → only `exc_ovf` pulses.
- RegWrite to `addr = 0` with `result = 7` → `wb_en` remains 0.
- `rst_n` low while in MEM with `dmem_req = 1` → all outputs 0 immediately. After release, a fresh ALU op writes back normally at N+1.
